// File: rtl/inst_fetcher_if.sv
`default_nettype none
//------------------------------------------------------------------
// inst_fetcher_if: fetch-stage handshakes (memory controller, decoder)
// Rev 1.0
//------------------------------------------------------------------
interface inst_fetcher_if;
   logic        if_to_mc_enable;
   logic [31:0] if_to_mc_pc;
   logic        mc_to_if_done;
   logic [31:0] mc_to_if_result;
   logic        dec_ready;
   logic        if_to_dec_valid;
   logic [31:0] if_to_dec_inst;
   logic [31:0] if_to_dec_pc;

   modport master (
      output if_to_mc_enable,
      output if_to_mc_pc,
      input  mc_to_if_done,
      input  mc_to_if_result,
      input  dec_ready,
      output if_to_dec_valid,
      output if_to_dec_inst,
      output if_to_dec_pc
   );

   modport slave (
      input  if_to_mc_enable,
      input  if_to_mc_pc,
      output mc_to_if_done,
      output mc_to_if_result,
      output dec_ready,
      input  if_to_dec_valid,
      input  if_to_dec_inst,
      input  if_to_dec_pc
   );
endinterface
`default_nettype wire

// File: rtl/inst_fetcher.sv
`default_nettype none
//------------------------------------------------------------------
// inst_fetcher: fetch PC + direct-mapped one-word-line I-cache to decode
// Rev 1.0
//------------------------------------------------------------------
module inst_fetcher #(
   parameter int unsigned ICACHE_IDX_BITS = 8,
   parameter logic [31:0] RESET_PC        = 32'h0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rdy,
   input  logic           clr,
   input  logic [31:0]    clr_target_pc,
   inst_fetcher_if.master bus
);
   localparam int unsigned c_lines    = 1 << ICACHE_IDX_BITS;
   localparam int unsigned c_tag_bits = 30 - ICACHE_IDX_BITS;

   localparam logic [1:0] c_lookup    = 2'd0;
   localparam logic [1:0] c_miss_wait = 2'd1;
   localparam logic [1:0] c_discard   = 2'd2;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic        r_mc_en;
   logic        w_mc_en_nxt;
   logic [31:0] r_mc_pc;
   logic [31:0] w_mc_pc_nxt;
   logic        r_dec_valid;
   logic        w_dec_valid_nxt;
   logic [31:0] r_dec_inst;
   logic [31:0] w_dec_inst_nxt;
   logic [31:0] r_dec_pc;
   logic [31:0] w_dec_pc_nxt;

   logic [c_lines-1:0]    r_line_valid;
   logic [c_tag_bits-1:0] r_tag  [c_lines];
   logic [31:0]           r_data [c_lines];

   logic [ICACHE_IDX_BITS-1:0] w_idx;
   logic [ICACHE_IDX_BITS-1:0] w_fill_idx;
   logic [c_tag_bits-1:0]      w_tag;
   logic [c_tag_bits-1:0]      w_fill_tag;
   logic                       w_hit;
   logic                       w_slot_free;
   logic                       w_fill;

   assign w_idx       = r_pc[ICACHE_IDX_BITS+1:2];
   assign w_tag       = r_pc[31:ICACHE_IDX_BITS+2];
   // Fills always use the outstanding request address: pc may already be redirected.
   assign w_fill_idx  = r_mc_pc[ICACHE_IDX_BITS+1:2];
   assign w_fill_tag  = r_mc_pc[31:ICACHE_IDX_BITS+2];
   assign w_hit       = r_line_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_slot_free = !r_dec_valid || bus.dec_ready;

   always_ff @(posedge clk) begin : p_state_reg
      if (!rst) begin
         r_state <= c_lookup;
      end else if (rdy) begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin : p_next_state
      w_state_nxt = r_state;
      case (r_state)
         c_lookup: begin
            if (!clr && w_slot_free && !w_hit) begin
               w_state_nxt = c_miss_wait;
            end
         end
         c_miss_wait: begin
            if (bus.mc_to_if_done) begin
               w_state_nxt = c_lookup;
            end else if (clr) begin
               w_state_nxt = c_discard;
            end
         end
         c_discard: begin
            if (bus.mc_to_if_done) begin
               w_state_nxt = c_lookup;
            end
         end
         default: w_state_nxt = c_lookup;
      endcase
   end

   always_comb begin : p_outputs
      w_pc_nxt        = r_pc;
      w_mc_en_nxt     = r_mc_en;
      w_mc_pc_nxt     = r_mc_pc;
      w_dec_valid_nxt = r_dec_valid && !bus.dec_ready;
      w_dec_inst_nxt  = r_dec_inst;
      w_dec_pc_nxt    = r_dec_pc;
      w_fill          = 1'b0;
      case (r_state)
         c_lookup: begin
            if (!clr && w_slot_free) begin
               if (w_hit) begin
                  w_dec_valid_nxt = 1'b1;
                  w_dec_inst_nxt  = r_data[w_idx];
                  w_dec_pc_nxt    = r_pc;
                  w_pc_nxt        = r_pc + 32'd4;
               end else begin
                  w_mc_en_nxt = 1'b1;
                  w_mc_pc_nxt = r_pc;
               end
            end
         end
         c_miss_wait, c_discard: begin
            // Enable must fall on the done edge so the controller never relaunches.
            if (bus.mc_to_if_done) begin
               w_fill      = 1'b1;
               w_mc_en_nxt = 1'b0;
            end
         end
         default: ;
      endcase
      if (clr) begin
         w_pc_nxt        = clr_target_pc;
         w_dec_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin : p_datapath
      if (!rst) begin
         r_pc         <= RESET_PC;
         r_mc_en      <= 1'b0;
         r_mc_pc      <= 32'h0;
         r_dec_valid  <= 1'b0;
         r_dec_inst   <= 32'h0;
         r_dec_pc     <= 32'h0;
         r_line_valid <= '0;
      end else if (rdy) begin
         r_pc        <= w_pc_nxt;
         r_mc_en     <= w_mc_en_nxt;
         r_mc_pc     <= w_mc_pc_nxt;
         r_dec_valid <= w_dec_valid_nxt;
         r_dec_inst  <= w_dec_inst_nxt;
         r_dec_pc    <= w_dec_pc_nxt;
         if (w_fill) begin
            r_line_valid[w_fill_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin : p_cache_arrays
      if (rst && rdy && w_fill) begin
         r_tag[w_fill_idx]  <= w_fill_tag;
         r_data[w_fill_idx] <= bus.mc_to_if_result;
      end
   end

   assign bus.if_to_mc_enable = r_mc_en;
   assign bus.if_to_mc_pc     = r_mc_pc;
   assign bus.if_to_dec_valid = r_dec_valid;
   assign bus.if_to_dec_inst  = r_dec_inst;
   assign bus.if_to_dec_pc    = r_dec_pc;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetcher.sv
`default_nettype none
//------------------------------------------------------------------
// tb_inst_fetcher: directed vector table plus multi-cycle corner sequences
// Rev 1.0
//------------------------------------------------------------------
module tb_inst_fetcher;
   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        clr;
   logic [31:0] clr_target_pc;

   int n_cmp = 0;
   int n_bad = 0;

   inst_fetcher_if bus ();

   inst_fetcher #(
      .ICACHE_IDX_BITS (8),
      .RESET_PC        (32'h0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .clr           (clr),
      .clr_target_pc (clr_target_pc),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rdy_i;
      logic        clr_i;
      logic [31:0] tgt_i;
      logic        done_i;
      logic [31:0] res_i;
      logic        dr_i;
      logic        en;
      logic [31:0] mpc;
      logic        v;
      logic [31:0] inst;
      logic [31:0] dpc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic ry, logic c, logic [31:0] t, logic d, logic [31:0] r,
                               logic dr, logic en, logic [31:0] mpc, logic v,
                               logic [31:0] inst, logic [31:0] dpc);
      vec_t x;
      x.rdy_i = ry; x.clr_i = c; x.tgt_i = t; x.done_i = d; x.res_i = r; x.dr_i = dr;
      x.en = en; x.mpc = mpc; x.v = v; x.inst = inst; x.dpc = dpc;
      return x;
   endfunction

   task automatic chk(input string nm, input logic en, input logic [31:0] mpc, input logic v,
                      input logic [31:0] inst, input logic [31:0] dpc, input bit slot);
      bit bad;
      n_cmp++;
      bad = (bus.if_to_mc_enable !== en) || (bus.if_to_mc_pc !== mpc) ||
            (bus.if_to_dec_valid !== v);
      if (slot) bad = bad || (bus.if_to_dec_inst !== inst) || (bus.if_to_dec_pc !== dpc);
      if (bad) begin
         n_bad++;
         $display("FAIL %s: got en=%0b mc_pc=%h valid=%0b inst=%h pc=%h, want en=%0b mc_pc=%h valid=%0b inst=%h pc=%h",
                  nm, bus.if_to_mc_enable, bus.if_to_mc_pc, bus.if_to_dec_valid,
                  bus.if_to_dec_inst, bus.if_to_dec_pc, en, mpc, v, inst, dpc);
      end
   endtask

   task automatic cyc(input logic c, input logic [31:0] t, input logic d, input logic [31:0] r);
      clr = c; clr_target_pc = t;
      bus.mc_to_if_done = d; bus.mc_to_if_result = r;
      @(posedge clk);
      #1;
      clr = 1'b0;
      bus.mc_to_if_done = 1'b0;
   endtask

   task automatic idle();
      cyc(1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; clr = 1'b0; clr_target_pc = 32'h0;
      bus.mc_to_if_done = 1'b0; bus.mc_to_if_result = 32'h0; bus.dec_ready = 1'b1;

      // rdy clr tgt done res dr | en mc_pc valid inst pc
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        1,32'h0,0,32'h0,32'h0));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        1,32'h0,0,32'h0,32'h0));
      vecs.push_back(mk(1,0,32'h0,1,32'h00000013,1, 0,32'h0,0,32'h0,32'h0));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        0,32'h0,1,32'h00000013,32'h0));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        1,32'h4,0,32'h00000013,32'h0));
      vecs.push_back(mk(1,0,32'h0,1,32'h00100093,1, 0,32'h4,0,32'h00000013,32'h0));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        0,32'h4,1,32'h00100093,32'h4));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        1,32'h8,0,32'h00100093,32'h4));
      vecs.push_back(mk(1,0,32'h0,1,32'h00200113,1, 0,32'h8,0,32'h00100093,32'h4));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        0,32'h8,1,32'h00200113,32'h8));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        1,32'hC,0,32'h00200113,32'h8));
      vecs.push_back(mk(1,0,32'h0,1,32'h00300193,1, 0,32'hC,0,32'h00200113,32'h8));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        0,32'hC,1,32'h00300193,32'hC));
      vecs.push_back(mk(1,1,32'h0,0,32'h0,1,        0,32'hC,0,32'h00300193,32'hC));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        0,32'hC,1,32'h00000013,32'h0));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        0,32'hC,1,32'h00100093,32'h4));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        0,32'hC,1,32'h00200113,32'h8));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        0,32'hC,1,32'h00300193,32'hC));
      vecs.push_back(mk(1,1,32'h4,0,32'h0,1,        0,32'hC,0,32'h00300193,32'hC));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        0,32'hC,1,32'h00100093,32'h4));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(1,0,32'h0,0,32'h0,0,     0,32'hC,1,32'h00100093,32'h4));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        0,32'hC,1,32'h00200113,32'h8));
      vecs.push_back(mk(1,1,32'h0,0,32'h0,0,        0,32'hC,0,32'h00200113,32'h8));
      vecs.push_back(mk(0,0,32'h0,0,32'h0,1,        0,32'hC,0,32'h00200113,32'h8));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        0,32'hC,1,32'h00000013,32'h0));
      vecs.push_back(mk(1,1,32'hFFFFFFFC,0,32'h0,1, 0,32'hC,0,32'h00000013,32'h0));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        1,32'hFFFFFFFC,0,32'h00000013,32'h0));
      vecs.push_back(mk(1,0,32'h0,1,32'hDEADBEEF,1, 0,32'hFFFFFFFC,0,32'h00000013,32'h0));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        0,32'hFFFFFFFC,1,32'hDEADBEEF,32'hFFFFFFFC));
      vecs.push_back(mk(1,0,32'h0,0,32'h0,1,        0,32'hFFFFFFFC,1,32'h00000013,32'h0));

      repeat (2) @(posedge clk);
      #1;
      chk("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      rst = 1'b1;

      foreach (vecs[i]) begin
         rdy = vecs[i].rdy_i; bus.dec_ready = vecs[i].dr_i;
         clr = vecs[i].clr_i; clr_target_pc = vecs[i].tgt_i;
         bus.mc_to_if_done = vecs[i].done_i; bus.mc_to_if_result = vecs[i].res_i;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d", i), vecs[i].en, vecs[i].mpc, vecs[i].v, vecs[i].inst, vecs[i].dpc, 1'b1);
      end
      rdy = 1'b1; bus.dec_ready = 1'b1; clr = 1'b0; bus.mc_to_if_done = 1'b0;

      // Redirect while a miss on 0x20 is outstanding
      cyc(1, 32'h20, 0, 0);           chk("redir_clr0",   0, 32'hFFFFFFFC, 0, 0, 0, 0);
      idle();                         chk("redir_req",    1, 32'h20, 0, 0, 0, 0);
      idle();                         chk("redir_wait",   1, 32'h20, 0, 0, 0, 0);
      cyc(1, 32'h100, 0, 0);          chk("redir_clr",    1, 32'h20, 0, 0, 0, 0);
      idle();                         chk("disc_hold1",   1, 32'h20, 0, 0, 0, 0);
      idle();                         chk("disc_hold2",   1, 32'h20, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'hAAAA0020);     chk("disc_done",    0, 32'h20, 0, 0, 0, 0);
      idle();                         chk("redir_req2",   1, 32'h100, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'h11110100);     chk("redir_fill",   0, 32'h100, 0, 0, 0, 0);
      idle();                         chk("redir_first",  0, 32'h100, 1, 32'h11110100, 32'h100, 1);
      cyc(1, 32'h20, 0, 0);           chk("disc_clr",     0, 32'h100, 0, 0, 0, 0);
      idle();                         chk("disc_line",    0, 32'h100, 1, 32'hAAAA0020, 32'h20, 1);

      // clr coincident with done in MISS_WAIT
      idle();                         chk("cd_req",       1, 32'h24, 0, 0, 0, 0);
      cyc(1, 32'h0, 1, 32'h24242424); chk("cd_done",      0, 32'h24, 0, 0, 0, 0);
      idle();                         chk("cd_hit",       0, 32'h24, 1, 32'h00000013, 32'h0, 1);
      cyc(1, 32'h24, 0, 0);           chk("cd_clr",       0, 32'h24, 0, 0, 0, 0);
      idle();                         chk("cd_line",      0, 32'h24, 1, 32'h24242424, 32'h24, 1);

      // Aliasing: 0x400 evicts 0x000
      cyc(1, 32'h400, 0, 0);          chk("alias_clr",    0, 32'h24, 0, 0, 0, 0);
      idle();                         chk("alias_req",    1, 32'h400, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'h40404040);     chk("alias_fill",   0, 32'h400, 0, 0, 0, 0);
      idle();                         chk("alias_hit",    0, 32'h400, 1, 32'h40404040, 32'h400, 1);
      cyc(1, 32'h0, 0, 0);            chk("alias_clr0",   0, 32'h400, 0, 0, 0, 0);
      idle();                         chk("alias_evict",  1, 32'h0, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'h00000013);     chk("alias_refill", 0, 32'h0, 0, 0, 0, 0);
      idle();                         chk("alias_hit0",   0, 32'h0, 1, 32'h00000013, 32'h0, 1);

      // Reset while a miss is outstanding
      cyc(1, 32'h400, 0, 0);          chk("rm_clr",       0, 32'h0, 0, 0, 0, 0);
      idle();                         chk("rm_req",       1, 32'h400, 0, 0, 0, 0);
      idle();                         chk("rm_wait",      1, 32'h400, 0, 0, 0, 0);
      rst = 1'b0;
      idle();                         chk("rm_reset",     0, 32'h0, 0, 32'h0, 32'h0, 1);
      rst = 1'b1;
      idle();                         chk("rm_cold_req",  1, 32'h0, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'h00000013);     chk("rm_fill",      0, 32'h0, 0, 0, 0, 0);
      idle();                         chk("rm_hit",       0, 32'h0, 1, 32'h00000013, 32'h0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Instruction-fetch stage sitting directly upstream of the memory controller's instruction port and directly upstream of the decoder.
- Holds the architectural fetch PC and a direct-mapped, one-word-per-line instruction cache.
- On a hit, it hands the instruction to the decoder. On a miss, it issues a 4-byte fetch over the IF↔memory-controller handshake and fills the line.
- Redirects (branch mispredict / exception flush) arrive on clr with a target PC.

Parameters:
- ICACHE_IDX_BITS, 8, log2 of line count (256 lines × 32-bit word).
- RESET_PC, 32'h0, PC loaded at reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset; one clock. Reset acts on the clk edge where rst==0.
- rdy  in  1  global enable; when 0, all state holds.
- clr  in  1  flush/redirect pulse.
- clr_target_pc  in  32  new fetch PC, valid with clr.
- if_to_mc_enable  out  1  fetch request to the memory controller.
- if_to_mc_pc  out  32  fetch address; must be stable while the request is outstanding.
- mc_to_if_done  in  1  one-cycle pulse: word returned.
- mc_to_if_result  in  32  fetched word, valid with done.
- dec_ready  in  1  decoder can accept this cycle.
- if_to_dec_valid  out  1  instruction available.
- if_to_dec_inst  out  32  instruction.
- if_to_dec_pc  out  32  PC of the instruction.

Behaviour:
- Address split:
  - index = pc[ICACHE_IDX_BITS+1:2]
  - tag = pc[31:ICACHE_IDX_BITS+2]
  - pc[1:0] is ignored and assumed 0.
- Reset (rst==0 at an edge):
  - state=LOOKUP, pc=RESET_PC, all valid bits=0.
  - if_to_mc_enable=0, if_to_mc_pc=0.
  - if_to_dec_valid=0, if_to_dec_inst=0, if_to_dec_pc=0.
  - Reset mid-miss drops the request immediately. The controller's own reset is simultaneous.
- rdy==0: no register changes; outputs hold.
- Output register: a slot is consumed when if_to_dec_valid && dec_ready. The slot may be refilled in the same cycle it is consumed.
- State LOOKUP (slot free or being consumed):
  - Hit: register inst and pc into the slot, set if_to_dec_valid=1, pc<=pc+4. Latency is 1 cycle; throughput is 1 instruction/cycle on consecutive hits.
  - Miss: set if_to_mc_enable<=1 and if_to_mc_pc<=pc, then go to MISS_WAIT.
  - Slot full and not consumed: stall, with no lookup side effects.
- State MISS_WAIT:
  - Hold enable and address unchanged.
  - On mc_to_if_done:
    - Write the line: valid=1, tag, data=mc_to_if_result.
    - Deassert enable at the next edge. Enable must be 0 in the cycle after done so the controller does not relaunch.
    - Return to LOOKUP. The next cycle hits.
- State DISCARD:
  - Entered on clr while in MISS_WAIT. The controller does not abort instruction fetches, so the fetcher keeps enable and address stable until done.
  - On done: fill the line (the address is still legal), drop the enable, then go to LOOKUP at the redirected pc.
- clr, priority over all non-reset events:
  - pc<=clr_target_pc.
  - if_to_dec_valid<=0; the slot is discarded even if dec_ready is high.
  - LOOKUP → LOOKUP; MISS_WAIT → DISCARD; DISCARD stays DISCARD.
  - clr coincident with done in MISS_WAIT: fill, drop enable, go to LOOKUP with the new pc.
  - clr does not invalidate the cache.
- PC arithmetic: 32-bit wrap, so 0xFFFFFFFC+4 = 0.
- Only one memory request is ever outstanding. No prefetch.

Test Plan:
- Cold start, RESET_PC=0: enable=1, if_to_mc_pc=0 in the cycle after reset release. Done with 32'h00000013 gives if_to_dec_valid=1, inst=0x13, pc=0 one cycle after the fill-then-hit. Next request is to 0x4.
- Warm loop: fill 0x0–0xC, then clr to 0x0 with dec_ready=1. The bench must see 4 consecutive valid cycles with pcs 0,4,8,C and enable=0 throughout.
- Backpressure: dec_ready=0 for 5 cycles with a hit pending. valid, inst and pc are held constant and pc does not advance. dec_ready=1 then yields the next instruction on the following cycle.
- Redirect mid-miss: clr to 0x100 two cycles after a miss on 0x20. Address stays 0x20 until done. No decoder output for 0x20. The next request is to 0x100 and the first valid pc is 0x100.
- Aliasing (ICACHE_IDX_BITS=8): fetch 0x000 then 0x400 (same index, different tag). The second access misses and evicts. Refetching 0x000 issues a new request.
- Reset mid-miss: rst=0 during MISS_WAIT clears enable and valid the next edge. After release the fetcher requests RESET_PC, and the earlier line is a miss.
